// File: rtl/down_seq_checker_pkg.sv
// ----------------------------------------------------------------------------
// down_seq_pkg
// Shared definitions for the down-counter sequence checker:
//   - default WIDTH / HI / LO / RELOCK constants
//   - checker FSM state encoding (HUNT, ARM, LOCK)
//   - next_val(): successor of a legal count value (LO wraps to HI)
// No ports (package). The optional capture feature is controlled by the
// macro DOWN_SEQ_CHECKER_CAPTURE_EN in the interface and top files. This
// package does not depend on it.
// ----------------------------------------------------------------------------
package down_seq_pkg;

  localparam int DEF_WIDTH  = 3;
  localparam int DEF_HI     = 5;
  localparam int DEF_LO     = 2;
  localparam int DEF_RELOCK = 3;

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    ARM  = 2'd1,
    LOCK = 2'd2
  } state_e;

  // Successor in the down-count sequence: LO reloads HI, otherwise decrement.
  function automatic int unsigned next_val(input int unsigned v,
                                           input int unsigned hi,
                                           input int unsigned lo);
    return (v == lo) ? hi : (v - 1);
  endfunction

endpackage

// File: rtl/down_seq_checker_if.sv
// ----------------------------------------------------------------------------
// down_seq_checker_if
// Bundles the counter sample and the checker status outputs.
//   cnt_in, cnt_valid              : counter side -> checker
//   locked, err_pulse, err_cnt,
//   wrap_cnt, expected             : checker -> status/monitor logic
//   err_got, err_exp               : only with DOWN_SEQ_CHECKER_CAPTURE_EN
// Modports: master = counter/status side, slave = checker.
// ----------------------------------------------------------------------------
interface down_seq_checker_if #(
  parameter int WIDTH = down_seq_pkg::DEF_WIDTH
);

  logic [WIDTH-1:0] cnt_in;
  logic             cnt_valid;
  logic             locked;
  logic             err_pulse;
  logic [7:0]       err_cnt;
  logic [7:0]       wrap_cnt;
  logic [WIDTH-1:0] expected;
`ifdef DOWN_SEQ_CHECKER_CAPTURE_EN
  logic [WIDTH-1:0] err_got;
  logic [WIDTH-1:0] err_exp;

  modport master (
    output cnt_in, cnt_valid,
    input  locked, err_pulse, err_cnt, wrap_cnt, expected, err_got, err_exp
  );

  modport slave (
    input  cnt_in, cnt_valid,
    output locked, err_pulse, err_cnt, wrap_cnt, expected, err_got, err_exp
  );
`else
  modport master (
    output cnt_in, cnt_valid,
    input  locked, err_pulse, err_cnt, wrap_cnt, expected
  );

  modport slave (
    input  cnt_in, cnt_valid,
    output locked, err_pulse, err_cnt, wrap_cnt, expected
  );
`endif

endinterface

// File: rtl/down_seq_checker_sat_cnt8.sv
// ----------------------------------------------------------------------------
// sat_cnt8
// 8-bit event counter.
//   clk    : clock
//   clear  : synchronous active-low clear (to 0), highest priority
//   inc_i  : add one on this edge
//   cnt_o  : current count
// SAT=1 holds the count at 255; SAT=0 rolls over from 255 to 0.
// ----------------------------------------------------------------------------
module sat_cnt8 #(
  parameter bit SAT = 1'b1
) (
  input  logic       clk,
  input  logic       clear,
  input  logic       inc_i,
  output logic [7:0] cnt_o
);

  logic [7:0] cnt_q;
  logic       at_max;

  assign at_max = (cnt_q == 8'hFF);

  always_ff @(posedge clk) begin
    if (!clear) begin
      cnt_q <= 8'd0;
    end else if (inc_i && !(SAT && at_max)) begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/down_seq_checker.sv
// ----------------------------------------------------------------------------
// down_seq_checker
// Checks that a down counter follows HI, HI-1, ..., LO, HI, ...
// Ports:
//   clk   : clock, rising edge
//   clear : synchronous active-low reset
//   bus   : down_seq_checker_if.slave (cnt_in/cnt_valid in; locked,
//           err_pulse, err_cnt, wrap_cnt, expected out)
// All outputs are registered and reflect the sample taken on the same edge.
// Optional: define DOWN_SEQ_CHECKER_CAPTURE_EN to add err_got/err_exp, which
// latch the sample and expected value of the first error after reset.
// ----------------------------------------------------------------------------
module down_seq_checker
  import down_seq_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int HI     = DEF_HI,
  parameter int LO     = DEF_LO,
  parameter int RELOCK = DEF_RELOCK
) (
  input logic              clk,
  input logic              clear,
  down_seq_checker_if.slave bus
);

  localparam logic [WIDTH-1:0] HI_V  = WIDTH'(HI);
  localparam logic [WIDTH-1:0] LO_V  = WIDTH'(LO);
  localparam int               RUN_W = (RELOCK < 2) ? 1 : $clog2(RELOCK + 1);
  localparam logic [RUN_W-1:0] RELOCK_V = RUN_W'(RELOCK);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] expected_q, expected_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic [RUN_W-1:0] run_inc;
  logic             locked_q;
  logic             err_pulse_q;
  logic             err_d;
  logic             wrap_d;
  logic             legal;
  logic [WIDTH-1:0] v;
  logic [WIDTH-1:0] v_next;
  logic [7:0]       err_cnt_w;
  logic [7:0]       wrap_cnt_w;

  assign v       = bus.cnt_in;
  assign legal   = (v >= LO_V) && (v <= HI_V);
  assign v_next  = WIDTH'(next_val(32'(v), HI, LO));
  assign run_inc = run_q + 1'b1;

  always_ff @(posedge clk) begin
    if (!clear) begin
      state_q     <= HUNT;
      expected_q  <= HI_V;
      run_q       <= '0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      expected_q  <= expected_d;
      run_q       <= run_d;
      locked_q    <= (state_d == LOCK);
      err_pulse_q <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    expected_d = expected_q;
    run_d      = run_q;
    err_d      = 1'b0;
    wrap_d     = 1'b0;
    if (bus.cnt_valid) begin
      unique case (state_q)
        HUNT: begin
          if (legal) begin
            expected_d = v_next;
            run_d      = '0;
            state_d    = ARM;
          end else begin
            err_d = 1'b1;
          end
        end
        ARM: begin
          if (!legal) begin
            err_d   = 1'b1;
            state_d = HUNT;
          end else if (v == expected_q) begin
            expected_d = v_next;
            if (run_inc == RELOCK_V) begin
              run_d   = '0;
              state_d = LOCK;
            end else begin
              run_d = run_inc;
            end
          end else begin
            // Mismatch before lock is just a new starting point, not an error.
            expected_d = v_next;
            run_d      = '0;
          end
        end
        LOCK: begin
          if (!legal) begin
            err_d   = 1'b1;
            state_d = HUNT;
          end else if (v == expected_q) begin
            expected_d = v_next;
            wrap_d     = (v == HI_V);
          end else begin
            err_d      = 1'b1;
            expected_d = v_next;
            run_d      = '0;
            state_d    = ARM;
          end
        end
        default: begin
          state_d = HUNT;
        end
      endcase
    end
  end

  sat_cnt8 #(.SAT(1'b1)) u_err_cnt (
    .clk   (clk),
    .clear (clear),
    .inc_i (err_d),
    .cnt_o (err_cnt_w)
  );

  sat_cnt8 #(.SAT(1'b0)) u_wrap_cnt (
    .clk   (clk),
    .clear (clear),
    .inc_i (wrap_d),
    .cnt_o (wrap_cnt_w)
  );

  assign bus.locked    = locked_q;
  assign bus.err_pulse = err_pulse_q;
  assign bus.err_cnt   = err_cnt_w;
  assign bus.wrap_cnt  = wrap_cnt_w;
  assign bus.expected  = expected_q;

`ifdef DOWN_SEQ_CHECKER_CAPTURE_EN
  logic             cap_done_q;
  logic [WIDTH-1:0] err_got_q;
  logic [WIDTH-1:0] err_exp_q;

  always_ff @(posedge clk) begin
    if (!clear) begin
      cap_done_q <= 1'b0;
      err_got_q  <= '0;
      err_exp_q  <= '0;
    end else if (err_d && !cap_done_q) begin
      cap_done_q <= 1'b1;
      err_got_q  <= v;
      err_exp_q  <= expected_q;
    end
  end

  assign bus.err_got = err_got_q;
  assign bus.err_exp = err_exp_q;
`endif

endmodule
